// File: rtl/encrypted_ctrl_pkg.sv
// Shared constants and FSM state types for the encrypted-data FIFO controller.
package encrypted_ctrl_pkg;

  localparam int DATA_W      = 8;
  localparam int BLOCK_BYTES = 16;
  localparam int CNT_W       = 5;
  localparam int BLOCK_W     = DATA_W * BLOCK_BYTES;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BLOCK_BYTES - 1);

  typedef enum logic [1:0] {W_IDLE, W_LOAD, W_WRITE} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_REQ, R_SEND} rstate_t;

endpackage

// File: rtl/cipher_serializer.sv
// Holds one cipher block and presents it MSB byte first, advancing only on
// writes that the FIFO actually accepts.
module cipher_serializer
  import encrypted_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               n_rst,
  input  logic               load,
  input  logic [BLOCK_W-1:0] block_in,
  input  logic               clear,
  input  logic               active,
  input  logic               stall,
  output logic               w_enable,
  output logic [DATA_W-1:0]  byte_out,
  output logic               last_write
);

  logic [BLOCK_W-1:0] block_q, block_d;
  logic [CNT_W-1:0]   wcnt_q, wcnt_d;

  always_comb begin
    block_d    = load ? block_in : block_q;
    w_enable   = active & ~stall;
    last_write = w_enable & (wcnt_q == LAST_IDX);
    wcnt_d     = wcnt_q;
    if (clear) begin
      wcnt_d = '0;
    end else if (w_enable) begin
      wcnt_d = wcnt_q + CNT_W'(1);
    end
  end

  // Byte 0 is the top byte of the block.
  always_comb begin
    byte_out = '0;
    for (int i = 0; i < BLOCK_BYTES; i++) begin
      if (wcnt_q == CNT_W'(i)) begin
        byte_out = block_q[BLOCK_W-1-i*DATA_W -: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      block_q <= '0;
      wcnt_q  <= '0;
    end else begin
      block_q <= block_d;
      wcnt_q  <= wcnt_d;
    end
  end

endmodule

// File: rtl/encrypted_fifo_ctrl.sv
// Writer serializes AES blocks into the byte FIFO; reader drains whole blocks
// to the USB transmitter once a complete block is resident.
module encrypted_fifo_ctrl
  import encrypted_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               n_rst,
  input  logic               aes_valid,
  input  logic [BLOCK_W-1:0] cipher_block,
  output logic               aes_ack,
  output logic               fifo_w_enable,
  output logic [DATA_W-1:0]  fifo_w_data,
  input  logic               fifo_full,
  input  logic               fifo_empty,
  output logic               fifo_r_enable,
  input  logic [DATA_W-1:0]  fifo_r_data,
  output logic               tx_req,
  input  logic               tx_grant,
  input  logic               tx_byte_ready,
  output logic [DATA_W-1:0]  tx_data,
  output logic               tx_eop,
  output logic               busy
);

  wstate_t          wstate_q, wstate_d;
  rstate_t          rstate_q, rstate_d;
  logic [CNT_W-1:0] rcnt_q, rcnt_d;
  logic [1:0]       blocks_ready_q, blocks_ready_d;

  logic ser_load, ser_clear, ser_active, ser_last;
  logic writer_done, grant_take;

  assign ser_active = (wstate_q == W_WRITE);
  assign ser_clear  = (wstate_q == W_LOAD);

  cipher_serializer u_serializer (
    .clk        (clk),
    .n_rst      (n_rst),
    .load       (ser_load),
    .block_in   (cipher_block),
    .clear      (ser_clear),
    .active     (ser_active),
    .stall      (fifo_full),
    .w_enable   (fifo_w_enable),
    .byte_out   (fifo_w_data),
    .last_write (ser_last)
  );

  always_comb begin
    wstate_d    = wstate_q;
    aes_ack     = 1'b0;
    ser_load    = 1'b0;
    writer_done = 1'b0;
    case (wstate_q)
      W_IDLE: begin
        if (aes_valid) begin
          aes_ack  = 1'b1;
          ser_load = 1'b1;
          wstate_d = W_LOAD;
        end
      end
      W_LOAD:  wstate_d = W_WRITE;
      W_WRITE: begin
        if (ser_last) begin
          writer_done = 1'b1;
          wstate_d    = W_IDLE;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  // Pops are gated by empty so a misbehaving transmitter cannot advance rcnt.
  always_comb begin
    rstate_d      = rstate_q;
    rcnt_d        = rcnt_q;
    tx_req        = 1'b0;
    tx_data       = '0;
    tx_eop        = 1'b0;
    fifo_r_enable = 1'b0;
    grant_take    = 1'b0;
    case (rstate_q)
      R_IDLE: begin
        if (blocks_ready_q != 2'd0) rstate_d = R_REQ;
      end
      R_REQ: begin
        tx_req = 1'b1;
        if (tx_grant) begin
          grant_take = 1'b1;
          rcnt_d     = '0;
          rstate_d   = R_SEND;
        end
      end
      R_SEND: begin
        tx_data       = fifo_r_data;
        tx_eop        = (rcnt_q == LAST_IDX);
        fifo_r_enable = tx_byte_ready & ~fifo_empty;
        if (fifo_r_enable) begin
          rcnt_d = rcnt_q + CNT_W'(1);
          if (tx_eop) rstate_d = R_IDLE;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  always_comb begin
    blocks_ready_d = blocks_ready_q;
    case ({writer_done, grant_take})
      2'b10:   blocks_ready_d = blocks_ready_q + 2'd1;
      2'b01:   blocks_ready_d = blocks_ready_q - 2'd1;
      default: blocks_ready_d = blocks_ready_q;
    endcase
  end

  assign busy = (wstate_q != W_IDLE) | (rstate_q != R_IDLE) | (blocks_ready_q != 2'd0);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wstate_q       <= W_IDLE;
      rstate_q       <= R_IDLE;
      rcnt_q         <= '0;
      blocks_ready_q <= '0;
    end else begin
      wstate_q       <= wstate_d;
      rstate_q       <= rstate_d;
      rcnt_q         <= rcnt_d;
      blocks_ready_q <= blocks_ready_d;
    end
  end

endmodule

// File: tb/tb_encrypted_fifo_ctrl.sv
// Directed bench for encrypted_fifo_ctrl with a 16-deep behavioural FIFO and
// logs of every write, pop and ack observed on the falling edge.
module tb_encrypted_fifo_ctrl;

  logic         clk = 1'b0;
  logic         n_rst;
  logic         aes_valid;
  logic [127:0] cipher_block;
  logic         aes_ack;
  logic         fifo_w_enable;
  logic [7:0]   fifo_w_data;
  logic         fifo_full;
  logic         fifo_empty;
  logic         fifo_r_enable;
  logic [7:0]   fifo_r_data;
  logic         tx_req;
  logic         tx_grant;
  logic         tx_byte_ready;
  logic [7:0]   tx_data;
  logic         tx_eop;
  logic         busy;
  logic         force_empty;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic sat_seen = 1'b0;

  logic [7:0] wr_log[$];
  logic [7:0] rd_log[$];
  logic       eop_log[$];
  int         ack_cycles[$];

  logic [7:0] fifo_mem[16];
  logic [4:0] fifo_count;
  logic [3:0] fifo_wp, fifo_rp;

  always #5 clk = ~clk;

  encrypted_fifo_ctrl dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .aes_valid     (aes_valid),
    .cipher_block  (cipher_block),
    .aes_ack       (aes_ack),
    .fifo_w_enable (fifo_w_enable),
    .fifo_w_data   (fifo_w_data),
    .fifo_full     (fifo_full),
    .fifo_empty    (fifo_empty),
    .fifo_r_enable (fifo_r_enable),
    .fifo_r_data   (fifo_r_data),
    .tx_req        (tx_req),
    .tx_grant      (tx_grant),
    .tx_byte_ready (tx_byte_ready),
    .tx_data       (tx_data),
    .tx_eop        (tx_eop),
    .busy          (busy)
  );

  // Behavioural FIFO sharing the controller reset.
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      fifo_count <= '0;
      fifo_wp    <= '0;
      fifo_rp    <= '0;
    end else begin
      if (fifo_w_enable && fifo_count != 5'd16) begin
        fifo_mem[fifo_wp] <= fifo_w_data;
        fifo_wp <= fifo_wp + 4'd1;
      end
      if (fifo_r_enable && fifo_count != 5'd0) fifo_rp <= fifo_rp + 4'd1;
      fifo_count <= fifo_count
                    + ((fifo_w_enable && fifo_count != 5'd16) ? 5'd1 : 5'd0)
                    - ((fifo_r_enable && fifo_count != 5'd0) ? 5'd1 : 5'd0);
    end
  end

  assign fifo_full   = (fifo_count == 5'd16);
  assign fifo_empty  = (fifo_count == 5'd0) | force_empty;
  assign fifo_r_data = fifo_mem[fifo_rp];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (n_rst) begin
      if (aes_ack) ack_cycles.push_back(cyc);
      if (fifo_w_enable) wr_log.push_back(fifo_w_data);
      if (fifo_r_enable) begin
        rd_log.push_back(tx_data);
        eop_log.push_back(tx_eop);
      end
      if (dut.blocks_ready_q == 2'd3) sat_seen = 1'b1;
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [7:0] blk_byte(input logic [127:0] b, input int i);
    return b[127-8*i -: 8];
  endfunction

  function automatic logic [21:0] out_vec();
    return {aes_ack, fifo_w_enable, fifo_w_data, fifo_r_enable, tx_req, tx_data, tx_eop, busy};
  endfunction

  task automatic clear_logs();
    wr_log.delete();
    rd_log.delete();
    eop_log.delete();
    ack_cycles.delete();
  endtask

  // Presents one block, waits for the ack, then drops valid (ends in W_LOAD).
  task automatic send_block(input logic [127:0] blk);
    bit got = 0;
    cipher_block = blk;
    aes_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (aes_ack) begin got = 1; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    aes_valid = 1'b0;
    checks++;
    if (!got) begin errors++; $display("[TB] FAIL send_block_ack: got no aes_ack, required one"); end
  endtask

  // Waits for tx_req; returns just after a rising edge with the reader in R_REQ.
  task automatic wait_req(input int limit);
    bit got = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (tx_req) begin got = 1; break; end
    end
    @(posedge clk); #1;
    checks++;
    if (!got) begin errors++; $display("[TB] FAIL wait_req: tx_req=0 after %0d cycles, required 1", limit); end
  endtask

  task automatic wait_reads(input int n, input int limit);
    bit got = 0;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk); #1;
      if (rd_log.size() >= n) begin got = 1; break; end
    end
    checks++;
    if (!got) begin errors++; $display("[TB] FAIL wait_reads: got %0d pops, required %0d", rd_log.size(), n); end
  endtask

  task automatic test_reset();
    n_rst = 1'b0; aes_valid = 1'b0; cipher_block = '0; tx_grant = 1'b0;
    tx_byte_ready = 1'b0; force_empty = 1'b0;
    #3;
    checks++;
    if (out_vec() !== 22'h0) begin errors++; $display("[TB] FAIL reset_outputs: got %h required 000000", out_vec()); end
    @(negedge clk); n_rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b required 0", busy); end
  endtask

  task automatic test_reset_mid_write();
    bit got = 0;
    clear_logs();
    @(posedge clk); #1;
    cipher_block = 128'hFEDCBA98_76543210_0F1E2D3C_4B5A6978;
    aes_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (ack_cycles.size() != 0) aes_valid = 1'b0;
      if (wr_log.size() == 5) begin got = 1; break; end
    end
    checks++;
    if (!got) begin errors++; $display("[TB] FAIL midreset_writes: got %0d writes, required 5", wr_log.size()); end
    n_rst = 1'b0;
    aes_valid = 1'b0;
    #1;
    checks++;
    if (out_vec() !== 22'h0) begin errors++; $display("[TB] FAIL midreset_outputs: got %h required 000000", out_vec()); end
    @(negedge clk);
    checks++;
    if (fifo_empty !== 1'b1 || tx_req !== 1'b0) begin
      errors++; $display("[TB] FAIL midreset_fifo: empty=%b tx_req=%b required 1 0", fifo_empty, tx_req);
    end
    @(negedge clk); n_rst = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || tx_req !== 1'b0 || fifo_w_enable !== 1'b0) begin
      errors++; $display("[TB] FAIL midreset_after: busy=%b tx_req=%b wen=%b required 0 0 0", busy, tx_req, fifo_w_enable);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single_block();
    logic [127:0] blk = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    logic [7:0] exp;
    clear_logs();
    send_block(blk);
    @(negedge clk);
    checks++;
    if (fifo_w_enable !== 1'b0) begin errors++; $display("[TB] FAIL single_load_cycle: wen=%b required 0", fifo_w_enable); end
    @(negedge clk);
    checks++;
    if (fifo_w_enable !== 1'b1 || fifo_w_data !== 8'h00) begin
      errors++; $display("[TB] FAIL single_first_write: wen=%b data=%h required 1 00", fifo_w_enable, fifo_w_data);
    end
    @(posedge clk); #1;
    wait_req(40);
    checks++;
    if (wr_log.size() != 16) begin errors++; $display("[TB] FAIL single_write_count: got %0d required 16", wr_log.size()); end
    for (int i = 0; i < 16 && i < wr_log.size(); i++) begin
      exp = 8'(i * 17);
      checks++;
      if (wr_log[i] !== exp) begin errors++; $display("[TB] FAIL single_write[%0d]: got %h required %h", i, wr_log[i], exp); end
    end
    tx_grant = 1'b1; tx_byte_ready = 1'b1;
    @(posedge clk); #1;
    tx_grant = 1'b0;
    @(negedge clk);
    checks++;
    if (tx_req !== 1'b0) begin errors++; $display("[TB] FAIL single_req_drop: got %b required 0", tx_req); end
    wait_reads(16, 40);
    tx_byte_ready = 1'b0;
    for (int i = 0; i < 16 && i < rd_log.size(); i++) begin
      exp = 8'(i * 17);
      checks++;
      if (rd_log[i] !== exp || eop_log[i] !== (i == 15)) begin
        errors++; $display("[TB] FAIL single_read[%0d]: data=%h eop=%b required %h %b", i, rd_log[i], eop_log[i], exp, (i == 15));
      end
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || ack_cycles.size() != 1) begin
      errors++; $display("[TB] FAIL single_done: busy=%b acks=%0d required 0 1", busy, ack_cycles.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_throttle();
    logic [127:0] blk = 128'h13579BDF_2468ACE0_F0E1D2C3_B4A59687;
    int pops = 0;
    bit rdy;
    clear_logs();
    send_block(blk);
    wait_req(40);
    tx_grant = 1'b1;
    @(posedge clk); #1;
    tx_grant = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rdy = (i % 2 == 0);
      tx_byte_ready = rdy;
      @(negedge clk);
      checks++;
      if (fifo_r_enable !== rdy || tx_eop !== (pops == 15)) begin
        errors++; $display("[TB] FAIL throttle_cycle[%0d]: ren=%b eop=%b required %b %b", i, fifo_r_enable, tx_eop, rdy, (pops == 15));
      end
      if (rdy) begin
        checks++;
        if (tx_data !== blk_byte(blk, pops)) begin
          errors++; $display("[TB] FAIL throttle_data[%0d]: got %h required %h", pops, tx_data, blk_byte(blk, pops));
        end
        pops++;
      end
      @(posedge clk); #1;
    end
    tx_byte_ready = 1'b0;
    checks++;
    if (rd_log.size() != 16 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL throttle_total: pops=%0d busy=%b required 16 0", rd_log.size(), busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] blk_a = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
    logic [127:0] blk_b = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
    logic [7:0] exp;
    bit got = 0;
    clear_logs();
    cipher_block = blk_a;
    aes_valid = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (ack_cycles.size() == 1) cipher_block = blk_b;
      if (ack_cycles.size() == 2) begin aes_valid = 1'b0; got = 1; break; end
    end
    checks++;
    if (!got) begin errors++; $display("[TB] FAIL b2b_acks: got %0d acks, required 2", ack_cycles.size()); end
    repeat (10) @(posedge clk);
    @(negedge clk);
    checks++;
    if (wr_log.size() != 16 || fifo_full !== 1'b1 || fifo_w_enable !== 1'b0 || fifo_w_data !== blk_byte(blk_b, 0)) begin
      errors++; $display("[TB] FAIL b2b_stall: writes=%0d full=%b wen=%b data=%h required 16 1 0 %h",
                         wr_log.size(), fifo_full, fifo_w_enable, fifo_w_data, blk_byte(blk_b, 0));
    end
    checks++;
    if (tx_req !== 1'b1 || busy !== 1'b1) begin errors++; $display("[TB] FAIL b2b_req: tx_req=%b busy=%b required 1 1", tx_req, busy); end
    @(posedge clk); #1;
    tx_grant = 1'b1; tx_byte_ready = 1'b1;
    wait_reads(32, 120);
    tx_grant = 1'b0; tx_byte_ready = 1'b0;
    for (int i = 0; i < 32 && i < rd_log.size(); i++) begin
      exp = (i < 16) ? blk_byte(blk_a, i) : blk_byte(blk_b, i - 16);
      checks++;
      if (rd_log[i] !== exp || eop_log[i] !== (i % 16 == 15)) begin
        errors++; $display("[TB] FAIL b2b_read[%0d]: data=%h eop=%b required %h %b", i, rd_log[i], eop_log[i], exp, (i % 16 == 15));
      end
    end
    checks++;
    if (wr_log.size() != 32) begin errors++; $display("[TB] FAIL b2b_write_count: got %0d required 32", wr_log.size()); end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_three_blocks();
    logic [127:0] blks[3];
    logic [7:0] exp;
    bit got = 0;
    blks[0] = 128'hA5A5A5A5_5A5A5A5A_01020304_05060708;
    blks[1] = 128'h11223344_55667788_99AABBCC_DDEEFF00;
    blks[2] = 128'hC0FFEE00_BADC0DE5_77665544_33221100;
    clear_logs();
    tx_grant = 1'b1; tx_byte_ready = 1'b1;
    cipher_block = blks[0];
    aes_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (aes_ack) begin
        checks++;
        if (fifo_w_enable !== 1'b0) begin errors++; $display("[TB] FAIL three_ack_idle: wen=%b during ack, required 0", fifo_w_enable); end
      end
      @(posedge clk); #1;
      if (ack_cycles.size() >= 3) aes_valid = 1'b0;
      else cipher_block = blks[ack_cycles.size()];
      if (rd_log.size() >= 48) begin got = 1; break; end
    end
    tx_grant = 1'b0; tx_byte_ready = 1'b0; aes_valid = 1'b0;
    checks++;
    if (!got || ack_cycles.size() != 3) begin
      errors++; $display("[TB] FAIL three_totals: pops=%0d acks=%0d required 48 3", rd_log.size(), ack_cycles.size());
    end
    for (int k = 1; k < ack_cycles.size(); k++) begin
      checks++;
      if (ack_cycles[k] - ack_cycles[k-1] < 18) begin
        errors++; $display("[TB] FAIL three_ack_gap[%0d]: got %0d cycles required >=18", k, ack_cycles[k] - ack_cycles[k-1]);
      end
    end
    for (int i = 0; i < 48 && i < rd_log.size() && i < wr_log.size(); i++) begin
      exp = blk_byte(blks[i / 16], i % 16);
      checks++;
      if (wr_log[i] !== exp || rd_log[i] !== exp || eop_log[i] !== (i % 16 == 15)) begin
        errors++; $display("[TB] FAIL three_byte[%0d]: wr=%h rd=%h eop=%b required %h %h %b",
                           i, wr_log[i], rd_log[i], eop_log[i], exp, exp, (i % 16 == 15));
      end
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_empty_ready();
    logic [127:0] blk = 128'h89ABCDEF_01234567_FEDCBA98_76543210;
    clear_logs();
    send_block(blk);
    wait_req(40);
    tx_grant = 1'b1;
    @(posedge clk); #1;
    tx_grant = 1'b0;
    tx_byte_ready = 1'b1;
    repeat (15) begin @(posedge clk); #1; end
    force_empty = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (fifo_r_enable !== 1'b0 || tx_eop !== 1'b1) begin
        errors++; $display("[TB] FAIL empty_ready[%0d]: ren=%b eop=%b required 0 1", i, fifo_r_enable, tx_eop);
      end
      @(posedge clk); #1;
    end
    force_empty = 1'b0;
    @(negedge clk);
    checks++;
    if (fifo_r_enable !== 1'b1 || tx_eop !== 1'b1 || tx_data !== blk_byte(blk, 15)) begin
      errors++; $display("[TB] FAIL empty_release: ren=%b eop=%b data=%h required 1 1 %h", fifo_r_enable, tx_eop, tx_data, blk_byte(blk, 15));
    end
    @(posedge clk); #1;
    tx_byte_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (rd_log.size() != 16 || busy !== 1'b0 || tx_eop !== 1'b0) begin
      errors++; $display("[TB] FAIL empty_done: pops=%0d busy=%b eop=%b required 16 0 0", rd_log.size(), busy, tx_eop);
    end
    checks++;
    if (sat_seen !== 1'b0) begin errors++; $display("[TB] FAIL blocks_ready_saturation: reached 3, required never"); end
  endtask

  initial begin
    $display("[TB] starting encrypted_fifo_ctrl bench");
    test_reset();
    test_reset_mid_write();
    test_single_block();
    test_throttle();
    test_back_to_back();
    test_three_blocks();
    test_empty_ready();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
